// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter slice: frame line levels,
// FSM state encoding, the default bit period and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Line levels for the framing bits; the idle line sits at the stop level.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // 50 MHz system clock, 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each serial bit. Clearing restarts the period so a frame's first bit is
// exactly CLKS_PER_BIT cycles long.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Free-running divider with synchronous clear and wrap at the last cycle.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values and simulation order cannot matter.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign bit_end = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, optional even
// parity bit, 1 stop bit. Bytes arrive over a valid/ready handshake and are
// latched on acceptance; all outputs are registered.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = PARITY;
`endif
  localparam logic [2:0] ST_STOP   = STOP;

  localparam int         BW       = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic [2:0]           state;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 accept;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign accept = tx_valid && tx_ready;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .bit_end(bit_end)
  );

`ifdef UART_TX_PARITY_EN
  // Parity is computed once from the accepted byte, before shifting starts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= even_parity(tx_data);
    end
  end
`endif

  // Frame sequencer: drives the line one bit per divider period and
  // shifts the latched byte out LSB first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= STOP_BIT;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg    <= tx_data;
            tx       <= START_BIT;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            // Counter wraps back to zero as the last data bit ends.
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= ST_PARITY;
`else
              tx    <= STOP_BIT;
              state <= ST_STOP;
`endif
            end else begin
              tx    <= shreg[0];
              shreg <= shreg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            tx    <= STOP_BIT;
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          tx       <= STOP_BIT;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
